whack_grid_renderer: RTL and testbench
======================================

# whack_grid_renderer

Parametrised VGA renderer for the whack-a-mole game. It generates 640x480 timing on the 25 MHz pixel clock and draws a configurable grid of mole slots, any subset of which may hold a mole. Feedback flashes (correct, wrong, game-over blink) are timed in whole frames. Mole and feedback changes take effect only at frame boundaries, so the picture never tears. The block sits between the game FSM and the VGA pins; all inputs are synchronous to clk_pixel.

## Interface
- HPIXELS, 800, clocks per line
- VLINES, 521, lines per frame
- HPULSE, 96, hsync low width (clocks)
- VPULSE, 2, vsync low width (lines)
- HBP, 144, first active column
- HFP, 784, first column past active
- VBP, 31, first active line
- VFP, 511, first line past active
- GRID_COLS, 3, slot columns
- NUM_SLOTS, 9, slot count, row-major
- GRID_X0, 120, active-area x of slot 0
- GRID_Y0, 40, active-area y of slot 0
- SLOT_SIZE, 100, slot square side
- SLOT_PITCH, 150, slot-to-slot spacing on both axes
- MOLE_INSET, 20, mole square inset inside its slot
- FLASH_CORRECT_FRAMES, 6, frames of green after a correct guess
- FLASH_WRONG_FRAMES, 60, frames of red after a wrong guess
- BLINK_FRAMES, 30, game-over half-period in frames

Ports:
- clk_pixel  in  1  pixel clock, 25 MHz
- rst  in  1  asynchronous reset, active-high
- mole_mask  in  NUM_SLOTS  bit i set = mole in slot i
- guess_correct  in  1  one-cycle event pulse
- guess_wrong  in  1  one-cycle event pulse
- game_over  in  1  one-cycle event pulse
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- red  out  3  pixel red
- green  out  3  pixel green
- blue  out  2  pixel blue
- frame_start  out  1  one-cycle pulse with output pixel (0,0)

## Operation
- Counters: hc counts 0..HPIXELS-1. On wrap, vc counts 0..VLINES-1. The frame boundary is the cycle with hc==0 and vc==0.
- Slot i occupies column i%GRID_COLS and row i/GRID_COLS. Its origin is x=GRID_X0+col*SLOT_PITCH, y=GRID_Y0+row*SLOT_PITCH, as offsets from HBP and VBP.
- Slot geometry uses one rectangle comparator per slot, built with a generate loop. No dividers.
- Pixel priority, first match wins:
  - outside the active area: black;
  - mole square of a slot whose mole_q bit is set: yellow 111/111/00;
  - any slot square: white 111/111/11;
  - everything else: black.
- Flash override: while a flash is visible, slot and mole pixels become the flash colour. Background stays black.
  - CORRECT: green 000/111/00.
  - WRONG: red 111/000/00.
  - OVER with blink phase on: orange 111/100/00.
- mole_mask is sampled into mole_q only at the frame boundary.
- Events are OR-ed into sticky pending bits and applied at the next frame boundary, including an event arriving in the boundary cycle itself.
  - Apply priority: over > wrong > correct.
  - Applying an event clears the pending bits and the frame counter.
- FSM states, reset to IDLE:
  - IDLE: applies any pending event.
  - CORRECT: newer events restart the flash. At each boundary the frame counter increments. At count FLASH_CORRECT_FRAMES-1 the state returns to IDLE.
  - WRONG: same as CORRECT, using FLASH_WRONG_FRAMES.
  - OVER: blink phase starts on and toggles every BLINK_FRAMES frames. correct and wrong events are ignored. Only rst exits this state.

## Timing
- Pipeline: counters, then geometry decode register, then colour/sync output register.
- red, green, blue, hsync, vsync and frame_start appear 2 cycles after the counter value they describe. Sync is delayed so it stays aligned with the pixel data.
- hsync is low while the delayed hc < HPULSE. vsync is low while the delayed vc < VPULSE.
- Frame period is HPIXELS*VLINES = 416800 cycles.
- Reset values: hc=vc=0; hsync=1, vsync=1, rgb=0, frame_start=0; FSM IDLE; mole_q=0; pending=0.
- rst takes effect asynchronously at any point, including mid-frame or mid-flash. After release, counting restarts at (0,0).

## Configuration
- WHACK_FLASH_EN defined: pending bits, FSM, frame counter and colour override are present.
- WHACK_FLASH_EN undefined: those parts are removed, event inputs are ignored, and slot colours are never overridden. Timing and latency are unchanged.

## Test plan
- Release reset: hsync goes low 2 cycles later for 96 of every 800 cycles; vsync is low for 1600 cycles per frame; frame_start repeats every 416800 cycles.
- mole_mask=9'h010 at a boundary: in the next frame, pixel (hc=444, vc=271) is 111/111/00, pixel (hc=419, vc=271) is 111/111/11, and pixel (hc=200, vc=271) is 000.
- mole_mask changed mid-frame: the current frame is unchanged and the new mask is drawn from the next frame_start.
- guess_correct mid-frame: the next 6 frames show green slots with black background, then white/yellow resumes.
- guess_correct and guess_wrong in the same cycle: red for 60 frames. Then game_over: orange for 30 frames and black slots for 30 frames, repeating; a later guess_correct has no effect.
- rst asserted mid-flash: rgb=0 and hsync=vsync=1 immediately. After release, the first frame draws with no flash.

Source files
------------

// File: rtl/whack_grid_renderer.sv
// whack_grid_renderer: 640x480 VGA renderer that draws a grid of mole slots with frame-timed feedback flashes.
// Define WHACK_FLASH_EN to build the event/flash logic; without it, slot colours are never overridden.
module whack_grid_renderer #(
  parameter int HPIXELS              = 800,
  parameter int VLINES               = 521,
  parameter int HPULSE               = 96,
  parameter int VPULSE               = 2,
  parameter int HBP                  = 144,
  parameter int HFP                  = 784,
  parameter int VBP                  = 31,
  parameter int VFP                  = 511,
  parameter int GRID_COLS            = 3,
  parameter int NUM_SLOTS            = 9,
  parameter int GRID_X0              = 120,
  parameter int GRID_Y0              = 40,
  parameter int SLOT_SIZE            = 100,
  parameter int SLOT_PITCH           = 150,
  parameter int MOLE_INSET           = 20,
  parameter int FLASH_CORRECT_FRAMES = 6,
  parameter int FLASH_WRONG_FRAMES   = 60,
  parameter int BLINK_FRAMES         = 30
) (
  input  logic                 clk_pixel,
  input  logic                 rst,
  input  logic [NUM_SLOTS-1:0] mole_mask,
  input  logic                 guess_correct,
  input  logic                 guess_wrong,
  input  logic                 game_over,
  output logic                 hsync,
  output logic                 vsync,
  output logic [2:0]           red,
  output logic [2:0]           green,
  output logic [1:0]           blue,
  output logic                 frame_start
);
  localparam int HW = $clog2(HPIXELS);
  localparam int VW = $clog2(VLINES);
  logic [HW-1:0] hc_q, hc_d;
  logic [VW-1:0] vc_q, vc_d;
  logic [NUM_SLOTS-1:0] mole_q, in_slot, in_mole;
  logic [31:0] hx, vy, px, py;
  logic boundary, active;
  logic act_q, slot_px_q, mole_px_q, hs_q, vs_q, fs_q;
  logic [7:0] rgb_q, rgb_d, base_c, flash_c;
  logic hsync_q, vsync_q, fs2_q, flash_on;
  assign hc_d = (hc_q == HW'(HPIXELS-1)) ? '0 : hc_q + 1'b1;
  assign vc_d = (hc_q != HW'(HPIXELS-1)) ? vc_q : (vc_q == VW'(VLINES-1)) ? '0 : vc_q + 1'b1;
  assign boundary = hc_q == '0 && vc_q == '0;
  assign hx = 32'(hc_q);
  assign vy = 32'(vc_q);
  assign px = hx - 32'(HBP);
  assign py = vy - 32'(VBP);
  assign active = hx >= 32'(HBP) && hx < 32'(HFP) && vy >= 32'(VBP) && vy < 32'(VFP);
  // Slot origins are elaboration-time constants, so each slot is just a rectangle compare.
  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    localparam int OX = GRID_X0 + (i % GRID_COLS) * SLOT_PITCH;
    localparam int OY = GRID_Y0 + (i / GRID_COLS) * SLOT_PITCH;
    assign in_slot[i] = px >= 32'(OX) && px < 32'(OX + SLOT_SIZE) &&
                        py >= 32'(OY) && py < 32'(OY + SLOT_SIZE);
    assign in_mole[i] = mole_q[i] &&
                        px >= 32'(OX + MOLE_INSET) && px < 32'(OX + SLOT_SIZE - MOLE_INSET) &&
                        py >= 32'(OY + MOLE_INSET) && py < 32'(OY + SLOT_SIZE - MOLE_INSET);
  end
  assign base_c = !act_q ? 8'h00 : mole_px_q ? 8'b111_111_00 : slot_px_q ? 8'hff : 8'h00;
  assign rgb_d  = (flash_on && act_q && slot_px_q) ? flash_c : base_c;
`ifdef WHACK_FLASH_EN
  localparam logic [1:0] S_IDLE = 2'd0, S_CORRECT = 2'd1, S_WRONG = 2'd2, S_OVER = 2'd3;
  localparam int FCW = FLASH_CORRECT_FRAMES > BLINK_FRAMES ? FLASH_CORRECT_FRAMES : BLINK_FRAMES;
  localparam int FMAX = FLASH_WRONG_FRAMES > FCW ? FLASH_WRONG_FRAMES : FCW;
  localparam int CW = $clog2(FMAX + 1);
  logic [1:0] st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d, lim;
  logic ph_q, ph_d;
  logic [2:0] pend_q, pend_d, ev;
  assign ev  = pend_q | {game_over, guess_wrong, guess_correct};
  assign lim = (st_q == S_WRONG) ? CW'(FLASH_WRONG_FRAMES-1) : CW'(FLASH_CORRECT_FRAMES-1);
  // Every boundary either applies, ignores (OVER) or finds nothing pending, so pending always clears there.
  assign pend_d = boundary ? 3'b000 : ev;
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    ph_d  = ph_q;
    if (boundary) begin
      if (st_q == S_OVER) begin
        cnt_d = (cnt_q == CW'(BLINK_FRAMES-1)) ? '0 : cnt_q + 1'b1;
        ph_d  = (cnt_q == CW'(BLINK_FRAMES-1)) ? ~ph_q : ph_q;
      end else if (ev != 3'b000) begin
        st_d  = ev[2] ? S_OVER : ev[1] ? S_WRONG : S_CORRECT;
        cnt_d = '0;
        ph_d  = 1'b1;
      end else if (st_q != S_IDLE) begin
        st_d  = (cnt_q == lim) ? S_IDLE : st_q;
        cnt_d = (cnt_q == lim) ? '0 : cnt_q + 1'b1;
      end
    end
  end
  always_ff @(posedge clk_pixel or posedge rst) begin
    if (rst) begin
      st_q   <= S_IDLE;
      cnt_q  <= '0;
      ph_q   <= 1'b0;
      pend_q <= 3'b000;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      ph_q   <= ph_d;
      pend_q <= pend_d;
    end
  end
  assign flash_on = st_q != S_IDLE;
  assign flash_c  = (st_q == S_CORRECT) ? 8'b000_111_00 :
                    (st_q == S_WRONG)   ? 8'b111_000_00 :
                    ph_q                ? 8'b111_100_00 : 8'h00;
`else
  logic unused_ev;
  assign unused_ev = ^{guess_correct, guess_wrong, game_over};
  assign flash_on  = 1'b0;
  assign flash_c   = 8'h00;
`endif
  always_ff @(posedge clk_pixel or posedge rst) begin
    if (rst) begin
      hc_q      <= '0;
      vc_q      <= '0;
      mole_q    <= '0;
      act_q     <= 1'b0;
      slot_px_q <= 1'b0;
      mole_px_q <= 1'b0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      fs_q      <= 1'b0;
      rgb_q     <= 8'h00;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      fs2_q     <= 1'b0;
    end else begin
      hc_q      <= hc_d;
      vc_q      <= vc_d;
      mole_q    <= boundary ? mole_mask : mole_q;
      act_q     <= active;
      slot_px_q <= |in_slot;
      mole_px_q <= |in_mole;
      hs_q      <= hx >= 32'(HPULSE);
      vs_q      <= vy >= 32'(VPULSE);
      fs_q      <= boundary;
      rgb_q     <= rgb_d;
      hsync_q   <= hs_q;
      vsync_q   <= vs_q;
      fs2_q     <= fs_q;
    end
  end
  assign {red, green, blue} = rgb_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = fs2_q;
endmodule

// File: tb/tb_whack_grid_renderer.sv
// tb_whack_grid_renderer: randomized bench for whack_grid_renderer on a shrunken raster,
// checked every cycle against a frame-level pixel model.
module tb_whack_grid_renderer;
  localparam int HP = 40, VL = 30, HPU = 4, VPU = 2, HB = 6, HF = 38, VB = 3, VF = 29;
  localparam int GC = 3, NS = 9, GX0 = 1, GY0 = 1, SZ = 8, PT = 10, IN = 2;
  localparam int FC = 3, FW = 5, BL = 2;
  localparam int FRAME = HP * VL;
  logic clk_pixel = 1'b0, rst = 1'b0;
  logic [NS-1:0] mole_mask = '0;
  logic guess_correct = 1'b0, guess_wrong = 1'b0, game_over = 1'b0;
  logic hsync, vsync, frame_start;
  logic [2:0] red, green;
  logic [1:0] blue;
  whack_grid_renderer #(
    .HPIXELS(HP), .VLINES(VL), .HPULSE(HPU), .VPULSE(VPU), .HBP(HB), .HFP(HF), .VBP(VB), .VFP(VF),
    .GRID_COLS(GC), .NUM_SLOTS(NS), .GRID_X0(GX0), .GRID_Y0(GY0), .SLOT_SIZE(SZ), .SLOT_PITCH(PT),
    .MOLE_INSET(IN), .FLASH_CORRECT_FRAMES(FC), .FLASH_WRONG_FRAMES(FW), .BLINK_FRAMES(BL)
  ) dut (
    .clk_pixel(clk_pixel), .rst(rst), .mole_mask(mole_mask), .guess_correct(guess_correct),
    .guess_wrong(guess_wrong), .game_over(game_over), .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue), .frame_start(frame_start)
  );
  always #5 clk_pixel = ~clk_pixel;
  int vectors = 0, errors = 0;
  int mh, mv, kind, left, ofr, evp, ncyc, lastfs, hlow, vlow, nfs;
  logic [NS-1:0] mmask, nxt_mask;
  logic [2:0] mpend;
  logic [10:0] p1, p2;
  logic run = 1'b0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask
  // Kind: 0 none, 1 correct, 2 wrong, 3 game over (ofr = frames since it began).
  function automatic logic [7:0] pix(int h, int v);
    int x, y, ox, oy;
    bit slot, mole;
    if (h < HB || h >= HF || v < VB || v >= VF) return 8'h00;
    x = h - HB;
    y = v - VB;
    slot = 0;
    mole = 0;
    for (int i = 0; i < NS; i++) begin
      ox = GX0 + (i % GC) * PT;
      oy = GY0 + (i / GC) * PT;
      if (x >= ox && x < ox + SZ && y >= oy && y < oy + SZ) begin
        slot = 1;
        if (mmask[i] && x >= ox + IN && x < ox + SZ - IN && y >= oy + IN && y < oy + SZ - IN) mole = 1;
      end
    end
    if (!slot) return 8'h00;
    if (kind == 1) return 8'b000_111_00;
    if (kind == 2) return 8'b111_000_00;
    if (kind == 3) return ((ofr / BL) % 2 == 0) ? 8'b111_100_00 : 8'h00;
    return mole ? 8'b111_111_00 : 8'hff;
  endfunction
  task automatic model_reset();
    mh = 0; mv = 0; mmask = '0; kind = 0; left = 0; ofr = 0; mpend = 3'b000;
    p1 = 11'b0_11_00000000;
    p2 = p1;
    hlow = 0; vlow = 0; lastfs = -1;
  endtask
  // Advances the model across the upcoming rising edge, using the inputs now applied.
  task automatic model_step();
    logic [2:0] ev;
    ev = mpend | {game_over, guess_wrong, guess_correct};
    if (mh == 0 && mv == 0) begin
      mmask = mole_mask;
      mpend = 3'b000;
`ifdef WHACK_FLASH_EN
      if (kind == 3) ofr++;
      else if (ev[2]) begin kind = 3; ofr = 0; end
      else if (ev[1]) begin kind = 2; left = FW; end
      else if (ev[0]) begin kind = 1; left = FC; end
      else if (kind != 0) begin left--; if (left == 0) kind = 0; end
`endif
    end else mpend = ev;
    p2 = p1;
    p1 = {mh == 0 && mv == 0, mh >= HPU, mv >= VPU, pix(mh, mv)};
    mh++;
    if (mh == HP) begin mh = 0; mv = (mv + 1) % VL; end
  endtask
  task automatic cyc(input logic [2:0] force_ev);
    logic [2:0] ev;
    @(negedge clk_pixel);
    ncyc++;
    if (run) begin
      chk("pix", {frame_start, hsync, vsync, red, green, blue}, p2);
      if (!hsync) hlow++;
      else begin if (hlow != 0) chk("hsync_w", hlow, HPU); hlow = 0; end
      if (!vsync) vlow++;
      else begin if (vlow != 0) chk("vsync_w", vlow, VPU * HP); vlow = 0; end
      if (frame_start) begin
        nfs++;
        if (lastfs >= 0) chk("fs_period", ncyc - lastfs, FRAME);
        lastfs = ncyc;
      end
    end
    mole_mask = nxt_mask;
    ev = force_ev;
    if (evp != 0) begin
      if ($urandom_range(evp - 1) == 0) ev[0] = 1'b1;
      if ($urandom_range(evp - 1) == 0) ev[1] = 1'b1;
    end
    {game_over, guess_wrong, guess_correct} = ev;
    if (!rst) model_step();
  endtask
  task automatic hit_rst();
    #2 rst = 1'b1;
    #1;
    chk("rst_rgb", {red, green, blue}, 8'h00);
    chk("rst_sync", {hsync, vsync}, 2'b11);
    chk("rst_fs", frame_start, 1'b0);
    model_reset();
  endtask
  task automatic release_rst();
    rst = 1'b0;
    model_step();
  endtask
  initial begin
    ncyc = 0; nfs = 0; evp = 0; nxt_mask = '0;
    model_reset();
    #1 rst = 1'b1;
    #1 run = 1'b1;
    repeat (3) cyc(3'b000);
    nxt_mask = 9'h010;
    release_rst();
    repeat (2 * FRAME) cyc(3'b000);
    repeat (FRAME / 2) cyc(3'b000);
    nxt_mask = NS'($urandom);
    repeat (2 * FRAME) cyc(3'b000);
    cyc(3'b001);
    repeat ((FC + 2) * FRAME) cyc(3'b000);
    repeat (FRAME / 3) cyc(3'b000);
    cyc(3'b011);
    repeat ((FW + 2) * FRAME) cyc(3'b000);
    evp = 1500;
    for (int k = 0; k < 24; k++) begin
      nxt_mask = NS'($urandom);
      repeat ($urandom_range(900, 300)) cyc(3'b000);
    end
    evp = 0;
    cyc(3'b100);
    repeat (3 * FRAME) cyc(3'b000);
    cyc(3'b001);
    repeat (5 * FRAME + FRAME / 3) cyc(3'b000);
    hit_rst();
    repeat (2) cyc(3'b000);
    nxt_mask = NS'($urandom);
    release_rst();
    repeat (2 * FRAME + 10) cyc(3'b000);
    chk("fs_seen", 32'(nfs > 25), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
